shift_add_mul_ctrl: RTL and testbench
=====================================

SHIFT_ADD_MUL_CTRL -- requirements
Module: shift_add_mul_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a multiply; sampled at a rising edge.
REQ-005 a  input  4  multiplicand, unsigned.
REQ-006 b  input  4  multiplier, unsigned.
REQ-007 busy  output  1  high while in CALC.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  8  registered unsigned result a*b.
REQ-010 The block SHALL instantiate the team 4-bit adder `addition` (a, b, carry_in, carry_out, sum) as its only arithmetic resource, with carry_in tied to 0.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL be accepted:
- a, b and the internal registers SHALL be latched as mcand<=a, hi<=0, lo<=b, cnt<=0.
- The next state SHALL be CALC.
REQ-013 start SHALL be ignored in CALC, and operand changes during CALC SHALL have no effect.
REQ-014 Each CALC edge SHALL perform one iteration:
- If lo[0]=1, {c,s} = adder(hi, mcand); otherwise {c,s} = {0,hi}.
- Then {hi,lo} <= {c, s, lo[3:1]}.
- cnt increments by 1.
REQ-015 After the 4th iteration (cnt=3 at the edge), the next state SHALL be DONE and product SHALL be loaded with {hi,lo} as it is after that shift.
REQ-016 Latency:
- Start accepted at edge N gives busy=1 after edges N..N+3.
- Iterations occur at edges N+1..N+4.
- done=1 and busy=0 SHALL hold for exactly the one cycle after edge N+4.
REQ-017 DONE SHALL last one cycle, then go to IDLE unless start is accepted per REQ-012.
REQ-018 product SHALL hold its value until the next load, including through IDLE and the next CALC.
REQ-019 done SHALL never be 1 outside DONE, and busy SHALL never be 1 outside CALC.
REQ-020 The result SHALL be exact for all 256 operand pairs (max 15*15=225=8'hE1); the adder carry_out SHALL be retained as bit 7 of the shift.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, product=8'h00, hi=lo=mcand=0 and cnt=0, independent of clk.
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release the block SHALL wait in IDLE for start.
REQ-023 A start at the first edge after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro ZERO_BYPASS_EN SHALL select zero-operand handling:
- Defined: an accepted start with a==0 or b==0 SHALL go directly to DONE at edge N, with product=8'h00, done=1 in the cycle after edge N, and busy never asserted.
- Undefined: zero operands SHALL take the full CALC path per REQ-016.

Verification
REQ-025 a=3, b=5, start pulsed at edge N -> busy high 4 cycles, then done=1 one cycle after edge N+4 with product=8'h0F.
REQ-026 a=15, b=15 -> product=8'hE1, exercising adder carry_out.
REQ-027 a=7, b=9 started, then start pulsed again with a=2, b=2 during CALC -> second start ignored, product=8'h3F.
REQ-028 start held high in DONE with a=4, b=4 -> back-to-back accept, next done 4 cycles later with product=8'h10, and 8'h3F held until that load.
REQ-029 rst_n=0 for 1 ns at the 2nd CALC cycle -> outputs 0 immediately, no done, next normal start succeeds.
REQ-030 a=0, b=9 -> with ZERO_BYPASS_EN, done 1 cycle after acceptance, product=8'h00; without it, done after 4 iterations, product=8'h00.

Source files
------------

// File: rtl/shift_add_mul_ctrl.sv
`timescale 1ns/1ps
// shift_add_mul_ctrl: 4x4 unsigned shift-add multiplier, one iteration per clock.
// Ports: clk, rst_n (async, active low), start, a, b in; busy, done, product out.
// Optional: define ZERO_BYPASS_EN to finish zero-operand requests without CALC.

// addition: 4-bit ripple adder, the shared arithmetic resource.
// Ports: a, b, carry_in in; sum, carry_out out.
module addition (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] sum
);

  logic [4:0] c;

  always_comb begin
    c[0] = carry_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i])
               | (a[i] & c[i])
               | (b[i] & c[i]);
    end
    carry_out = c[4];
  end

endmodule

module shift_add_mul_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [3:0] mcand;
  logic [3:0] hi;
  logic [3:0] lo;
  logic [1:0] cnt;

  logic       add_c;
  logic [3:0] add_s;
  logic       step_c;
  logic [3:0] step_s;

  logic       accept;
  logic       zero_op;
  logic       last;

  addition u_add (
    .a         (hi),
    .b         (mcand),
    .carry_in  (1'b0),
    .carry_out (add_c),
    .sum       (add_s)
  );

  // Partial-product select: add mcand only when
  // the current multiplier bit is set.
  always_comb begin
    step_c = 1'b0;
    step_s = hi;
    if (lo[0]) begin
      step_c = add_c;
      step_s = add_s;
    end
  end

  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (cnt == 2'd3);

`ifdef ZERO_BYPASS_EN
  assign zero_op = (a == 4'd0) || (b == 4'd0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = zero_op ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (accept) begin
          state_nx = zero_op ? DONE : CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: {hi,lo} shifts right by one each
  // CALC edge with the adder carry entering at the
  // top, so the 9-bit partial sum never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= 4'd0;
      hi      <= 4'd0;
      lo      <= 4'd0;
      cnt     <= 2'd0;
      product <= 8'h00;
    end else if (accept) begin
      mcand <= a;
      hi    <= 4'd0;
      lo    <= b;
      cnt   <= 2'd0;
      if (zero_op) begin
        product <= 8'h00;
      end
    end else if (state == CALC) begin
      hi  <= {step_c, step_s[3:1]};
      lo  <= {step_s[0], lo[3:1]};
      cnt <= cnt + 2'd1;
      if (last) begin
        product <= {step_c, step_s, lo[3:1]};
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
`timescale 1ns/1ps
// Bench for shift_add_mul_ctrl: random and directed requests, scoreboard
// of a*b results compared whenever done is seen.
module tb_shift_add_mul_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

`ifdef ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [7:0] q[$];
  int         left;
  logic       exp_busy;
  logic       exp_done;
  logic [7:0] held;

  shift_add_mul_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm,
                              logic [7:0] act,
                              logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endfunction

  // Reference: a request is taken whenever no
  // multiply is in flight; it lasts 4 clocks
  // (or finishes at once for bypassed zeros).
  initial begin
    left     = 0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    held     = 8'h00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left     = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      held     = 8'h00;
      q.delete();
    end else begin
      exp_done = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) exp_done = 1'b1;
      end else if (start) begin
        if (BYP && (a == 0 || b == 0)) begin
          q.push_back(8'h00);
          exp_done = 1'b1;
        end else begin
          q.push_back(8'(int'(a) * int'(b)));
          left = 4;
        end
      end
      exp_busy = (left > 0);
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [7:0] e;
    chk("busy", 8'(busy), 8'(exp_busy));
    chk("done", 8'(done), 8'(exp_done));
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 8'(q.size()), 8'd1);
      end else begin
        e    = q.pop_front();
        held = e;
        chk("product", product, e);
      end
    end else begin
      chk("product_hold", product, held);
    end
  end

  task automatic drive(input logic s,
                       input logic [3:0] x,
                       input logic [3:0] y);
    @(negedge clk);
    start = s;
    a     = x;
    b     = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    logic [3:0] x;
    logic [3:0] y;
    rst_n = 1'b1;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_product", product, 8'h00);
    @(negedge clk);
    @(negedge clk);
    // start ready at the first edge after release
    start = 1'b1;
    a     = 4'd3;
    b     = 4'd5;
    rst_n = 1'b1;
    idle(7);

    drive(1'b1, 4'd15, 4'd15);
    idle(7);

    // second start during CALC must be ignored,
    // start held into DONE is accepted
    drive(1'b1, 4'd7, 4'd9);
    drive(1'b1, 4'd2, 4'd2);
    drive(1'b1, 4'd2, 4'd2);
    drive(1'b0, 4'd2, 4'd2);
    drive(1'b0, 4'd0, 4'd0);
    drive(1'b1, 4'd4, 4'd4);
    idle(7);

    // abort in the second CALC cycle
    drive(1'b1, 4'd6, 4'd7);
    drive(1'b0, 4'd0, 4'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #0.5;
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_product", product, 8'h00);
    #0.5 rst_n = 1'b1;
    idle(3);
    drive(1'b1, 4'd5, 4'd5);
    idle(7);

    drive(1'b1, 4'd0, 4'd9);
    idle(7);
    drive(1'b1, 4'd9, 4'd0);
    drive(1'b1, 4'd0, 4'd0);
    idle(7);

    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 4))
        0:       x = 4'd0;
        1:       x = 4'd15;
        default: x = 4'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       y = 4'd0;
        1:       y = 4'd15;
        default: y = 4'($urandom);
      endcase
      drive($urandom_range(0, 2) == 0, x, y);
    end
    idle(8);
    chk("drain", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
